// File: rtl/block_emitter_pkg.sv
// Shared encodings, ASCII constants and token lengths for the begin/end token emitter.
package block_emitter_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DEPTH_W = 8;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned CMD_W   = 2;

  localparam logic [CMD_W-1:0] CMD_OPEN  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_CLOSE = 2'b01;
  localparam logic [CMD_W-1:0] CMD_SPACE = 2'b10;
  localparam logic [CMD_W-1:0] CMD_NOP   = 2'b11;

  // State codes double as the token kind fed to the character ROM.
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_OPEN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_CLOSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_SPACE = 2'd3;

  localparam logic [CHAR_W-1:0] CH_SPACE    = 8'h20;
  localparam logic [CHAR_W-1:0] CH_B        = 8'h62;
  localparam logic [CHAR_W-1:0] CH_E        = 8'h65;
  localparam logic [CHAR_W-1:0] CH_G        = 8'h67;
  localparam logic [CHAR_W-1:0] CH_I        = 8'h69;
  localparam logic [CHAR_W-1:0] CH_N        = 8'h6E;
  localparam logic [CHAR_W-1:0] CH_D        = 8'h64;
  localparam logic [CHAR_W-1:0] CASE_OFFSET = 8'h20;

  localparam int unsigned OPEN_LEN  = 6;
  localparam int unsigned CLOSE_LEN = 4;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  // Index of the final character of the token emitted in a given state.
  function automatic logic [IDX_W-1:0] last_idx(input logic [STATE_W-1:0] st);
    case (st)
      ST_OPEN:  last_idx = IDX_W'(OPEN_LEN - 1);
      ST_CLOSE: last_idx = IDX_W'(CLOSE_LEN - 1);
      default:  last_idx = '0;
    endcase
  endfunction

endpackage

// File: rtl/block_char_rom.sv
// Combinational lookup from (token kind, character index, case) to an ASCII character.
module block_char_rom
  import block_emitter_pkg::*;
(
  input  logic [STATE_W-1:0] kind,
  input  logic [IDX_W-1:0]   idx,
  input  logic               upper,
  output logic [CHAR_W-1:0]  ch_c
);

  logic [CHAR_W-1:0] lower;

  always_comb begin
    lower = CH_SPACE;
    case (kind)
      ST_OPEN: begin
        case (idx)
          3'd0:    lower = CH_B;
          3'd1:    lower = CH_E;
          3'd2:    lower = CH_G;
          3'd3:    lower = CH_I;
          3'd4:    lower = CH_N;
          default: lower = CH_SPACE;
        endcase
      end
      ST_CLOSE: begin
        case (idx)
          3'd0:    lower = CH_E;
          3'd1:    lower = CH_N;
          3'd2:    lower = CH_D;
          default: lower = CH_SPACE;
        endcase
      end
      default: lower = CH_SPACE;
    endcase
  end

  // Spaces are case-independent; only letters are shifted.
  assign ch_c = (upper && (lower != CH_SPACE)) ? lower - CASE_OFFSET : lower;

endmodule

// File: rtl/block_emitter.sv
// Command-driven "begin"/"end"/" " token emitter with nesting depth tracking and sticky error.
module block_emitter
  import block_emitter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               upper,
  output logic               cmd_ready,
  output logic               out_valid,
  output logic [CHAR_W-1:0]  out,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               error
);

  logic [STATE_W-1:0] state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               upper_q, upper_n;
  logic [DEPTH_W-1:0] depth_n;
  logic               error_n;
  logic [CHAR_W-1:0]  ch_n;
  logic               ready_n;
  logic               accept;

  assign accept = cmd_valid && cmd_ready;

  // Next-state, index, depth and error; rejected commands land in IDLE.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    upper_n = upper_q;
    depth_n = depth;
    error_n = error;
    if (accept) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      upper_n = upper;
      case (cmd)
        CMD_OPEN: begin
          if (depth == DEPTH_MAX) begin
            error_n = 1'b1;
          end else begin
            depth_n = depth + DEPTH_W'(1);
            state_n = ST_OPEN;
          end
        end
        CMD_CLOSE: begin
          if (depth == '0) begin
            error_n = 1'b1;
          end else begin
            depth_n = depth - DEPTH_W'(1);
            state_n = ST_CLOSE;
          end
        end
        CMD_SPACE: state_n = ST_SPACE;
        default:   state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (idx == last_idx(state)) begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end else begin
        idx_n = idx + IDX_W'(1);
      end
    end
  end

  block_char_rom u_rom (
    .kind  (state_n),
    .idx   (idx_n),
    .upper (upper_n),
    .ch_c  (ch_n)
  );

  assign ready_n = (state_n == ST_IDLE) || (idx_n == last_idx(state_n));

  // Outputs are registered from next-state values so the first character follows the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      upper_q   <= 1'b0;
      depth     <= '0;
      error     <= 1'b0;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      out       <= CH_SPACE;
      balanced  <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      upper_q   <= upper_n;
      depth     <= depth_n;
      error     <= error_n;
      cmd_ready <= ready_n;
      out_valid <= (state_n != ST_IDLE);
      out       <= (state_n != ST_IDLE) ? ch_n : CH_SPACE;
      balanced  <= (depth_n == '0);
    end
  end

endmodule

// File: tb/tb_block_emitter.sv
// Scoreboard bench for block_emitter: expected characters queued at accept, checked as emitted.
module tb_block_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b11;
  logic       upper = 1'b0;
  logic       cmd_ready, out_valid, balanced, error;
  logic [7:0] out, depth;

  localparam logic [1:0] OPEN = 2'b00, CLOSE = 2'b01, SPACE = 2'b10, NOP = 2'b11;

  int total = 0;
  int bad = 0;
  byte unsigned exp_q[$];
  int m_depth = 0;
  bit m_err = 1'b0;
  int gaps = 0;
  bit mon_en = 1'b0;
  int level = 0;
  bit chk_ok = 1'b1;
  string word = "";

  block_emitter dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .upper     (upper),
    .cmd_ready (cmd_ready),
    .out_valid (out_valid),
    .out       (out),
    .depth     (depth),
    .balanced  (balanced),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: scoreboard compare plus an independent begin/end nesting checker.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_char", 32'(out_valid), 32'd0);
        else check("char", 32'(out), 32'(exp_q.pop_front()));
        if (out == 8'h20) begin
          if (word.tolower() == "begin") level++;
          else if (word.tolower() == "end") begin
            level--;
            if (level < 0) chk_ok = 1'b0;
          end else if (word.len() != 0) chk_ok = 1'b0;
          word = "";
        end else begin
          word = $sformatf("%s%c", word, out);
        end
      end else begin
        check("idle_out", 32'(out), 32'h20);
        if (exp_q.size() != 0) gaps++;
      end
    end
  end

  task automatic push_tok(input string s, input logic u);
    byte unsigned c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (u && c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
      exp_q.push_back(c);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic u);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    upper = u;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    case (c)
      OPEN:  if (m_depth == 255) m_err = 1'b1; else begin m_depth++; push_tok("begin ", u); end
      CLOSE: if (m_depth == 0) m_err = 1'b1; else begin m_depth--; push_tok("end ", u); end
      SPACE: push_tok(" ", u);
      default: ;
    endcase
    #1;
    cmd_valid = 1'b0;
    check("depth", 32'(depth), 32'(m_depth));
    check("balanced", 32'(balanced), 32'(m_depth == 0));
    check("error", 32'(error), 32'(m_err));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'h20);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_balanced", 32'(balanced), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Single lower-case OPEN, then close it
    send(OPEN, 1'b0);
    drain();
    send(CLOSE, 1'b0);
    drain();

    // Back-to-back upper-case nesting
    send(OPEN, 1'b1);
    send(OPEN, 1'b1);
    send(CLOSE, 1'b1);
    send(CLOSE, 1'b1);
    drain();

    // SPACE and NOP
    send(SPACE, 1'b1);
    send(NOP, 1'b0);
    drain();
    check("nop_ready", 32'(cmd_ready), 32'd1);

    // Underflow CLOSE sets sticky error; a following OPEN works normally
    send(CLOSE, 1'b0);
    repeat (3) @(negedge clk);
    send(OPEN, 1'b0);
    send(CLOSE, 1'b1);
    drain();

    // Asynchronous reset in the middle of an OPEN token
    send(OPEN, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_out", 32'(out), 32'h20);
    check("abort_depth", 32'(depth), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_error", 32'(error), 32'd0);
    exp_q.delete();
    m_depth = 0;
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send(OPEN, 1'b1);
    drain();
    send(CLOSE, 1'b0);
    drain();

    // Random balanced sequence through the begin/end checker
    level = 0;
    chk_ok = 1'b1;
    word = "";
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 3);
      if (r == 1 && m_depth == 0) r = 0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(2'(r), 1'($urandom_range(0, 1)));
    end
    while (m_depth > 0) send(CLOSE, 1'($urandom_range(0, 1)));
    drain();
    check("checker_result", 32'(chk_ok && level == 0 && word.len() == 0), 32'd1);

    // Saturate depth at 255, then one more OPEN is rejected
    for (int i = 0; i < 255; i++) send(OPEN, 1'($urandom_range(0, 1)));
    send(OPEN, 1'b0);
    drain();
    check("sat_depth", 32'(depth), 32'd255);
    check("sat_error", 32'(error), 32'd1);
    check("sat_valid", 32'(out_valid), 32'd0);

    check("gaps", 32'(gaps), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_emitter.md
BLOCK_EMITTER -- requirements
Module: block_emitter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port cmd_valid, input, 1, command offered this cycle.
REQ-004 SHALL have port cmd, input, 2, command code: OPEN=2'b00, CLOSE=2'b01, SPACE=2'b10, NOP=2'b11.
REQ-005 SHALL have port upper, input, 1, letter case for the offered command: 1 = upper case, 0 = lower case.
REQ-006 SHALL have port cmd_ready, output, 1, block can accept a command this cycle.
REQ-007 SHALL have port out_valid, output, 1, out carries a character of an emitted token.
REQ-008 SHALL have port out, output, 8, ASCII character stream, one character per clk.
REQ-009 SHALL have port depth, output, 8, current nesting level (accepted OPENs minus accepted CLOSEs).
REQ-010 SHALL have port balanced, output, 1, equals (depth == 0).
REQ-011 SHALL have port error, output, 1, sticky flag for a rejected command.

Function
REQ-012 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; cmd and upper are latched at that edge.
REQ-013 States SHALL be IDLE, EMIT_OPEN, EMIT_CLOSE and EMIT_SPACE; a 3-bit index selects the character within the token.
REQ-014 An accepted OPEN SHALL emit "begin" followed by " " (6 characters) in the cycles after acceptance.
REQ-015 An accepted CLOSE SHALL emit "end" followed by " " (4 characters) in the cycles after acceptance.
REQ-016 An accepted SPACE SHALL emit a single " " with out_valid=1.
REQ-017 An accepted NOP SHALL emit nothing and SHALL leave the state at IDLE.
REQ-018 Latency: the first character SHALL appear in the cycle immediately after the accept edge; characters SHALL follow on consecutive cycles, with no backpressure.
REQ-019 When upper=1, letters SHALL be upper case ("BEGIN", "END"); the space character is case-independent.
REQ-020 When out_valid=0, out SHALL be 8'h20 (" "), so a downstream checker sees only whitespace between tokens.
REQ-021 cmd_ready SHALL be 1 in IDLE and in the final character cycle of a token, and 0 otherwise.
REQ-022 Back-to-back commands SHALL therefore produce a gap-free stream.
REQ-023 depth SHALL increment at the OPEN accept edge and decrement at the CLOSE accept edge.
REQ-024 A CLOSE offered while depth==0 SHALL be accepted, SHALL emit nothing, SHALL leave depth at 0, and SHALL set error.
REQ-025 An OPEN offered while depth==255 SHALL be accepted, SHALL emit nothing, SHALL leave depth at 255, and SHALL set error; depth never wraps.
REQ-026 A rejected command SHALL return the block to IDLE, or keep it in IDLE.
REQ-027 error SHALL remain 1 until reset; later valid commands SHALL operate normally.
REQ-028 cmd_valid=0 in the final character cycle SHALL return the block to IDLE on the next edge.

Reset
REQ-029 On reset the block SHALL be in IDLE with index=0, cmd_ready=1, out_valid=0, out=8'h20, depth=0, balanced=1 and error=0.
REQ-030 A reset asserted mid-token SHALL abort the token immediately, and no further characters of it SHALL appear.
REQ-031 After reset deasserts, the first accept edge SHALL behave as in REQ-018.

Structure
REQ-032 A shared package SHALL hold the cmd encodings, the state encodings, the ASCII constants (space, b/e/g/i/n/d in lower case, case offset 8'h20) and the token lengths (6 and 4).
REQ-033 One combinational sub-module, block_char_rom, SHALL map (token kind, index, upper) to an 8-bit character.
REQ-034 The FSM, index counter, depth counter and error flag SHALL reside in block_emitter.

Verification
REQ-035 Scenario: reset, then OPEN with upper=0 -> out = "b","e","g","i","n"," " on 6 consecutive cycles with out_valid=1; depth=1; balanced=0.
REQ-036 Scenario: OPEN, OPEN, CLOSE, CLOSE offered back-to-back with upper=1 -> gap-free "BEGIN BEGIN END END "; depth goes 1, 2, 1, 0; balanced=1 at end; error=0.
REQ-037 Scenario: CLOSE offered at depth 0 -> out stays 8'h20 with out_valid=0; depth=0; error=1, still 1 after a subsequent valid OPEN.
REQ-038 Scenario: 255 OPENs then one more OPEN -> depth=255; the last OPEN emits nothing; error=1.
REQ-039 Scenario: reset asserted after the 3rd character of an OPEN (asynchronously, between edges) -> next sampled cycle shows out_valid=0, out=8'h20, depth=0, cmd_ready=1.
REQ-040 Scenario: stream fed into the team's begin/end checker for a balanced random command sequence -> checker result=1 after the final token.
